// File: rtl/iotdf_pkg.sv
// Shared types and constants for the IoT data-filter sequencer.
// Geometry defaults describe one run: 12 groups x 8 words x 16 bytes.
package iotdf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [2:0] FN_MAX     = 3'd1;
    localparam logic [2:0] FN_MIN     = 3'd2;
    localparam logic [2:0] FN_AVG     = 3'd3;
    localparam logic [2:0] FN_EXTRACT = 3'd4;
    localparam logic [2:0] FN_EXCLUDE = 3'd5;
    localparam logic [2:0] FN_PMAX    = 3'd6;
    localparam logic [2:0] FN_PMIN    = 3'd7;

    // f4/f5 are pure compare/pass units with no state worth clocking.
    localparam logic [6:0] GATE_MASK = 7'b1100111;

    localparam int DEF_BYTES_PER_WORD  = 16;
    localparam int DEF_WORDS_PER_GROUP = 8;
    localparam int DEF_NUM_GROUPS      = 12;
    localparam int DEF_DRAIN_CYC       = 2;

endpackage

// File: rtl/iotdf_fn_dec.sv
// Decodes the host function select into a one-hot unit enable and its clock-gate mask.
// Purely combinational; fn_sel==0 selects nothing.
module iotdf_fn_dec
    import iotdf_pkg::*;
(
    input  logic [2:0] fn_sel,
    output logic [6:0] f_en,
    output logic [6:0] gate_en
);

    always_comb begin
        f_en = 7'd0;
        if (fn_sel != 3'd0) begin
            f_en = 7'd1 << (fn_sel - 3'd1);
        end
        gate_en = f_en & GATE_MASK;
    end

endmodule

// File: rtl/iotdf_ctrl.sv
// Sequencer for the IoT data-filter datapath: paces host bytes, counts bytes/words/groups,
// raises word/group strobes on the accepting cycle and holds done after the drain window.
module iotdf_ctrl
    import iotdf_pkg::*;
#(
    parameter int BYTES_PER_WORD  = DEF_BYTES_PER_WORD,
    parameter int WORDS_PER_GROUP = DEF_WORDS_PER_GROUP,
    parameter int NUM_GROUPS      = DEF_NUM_GROUPS,
    parameter int DRAIN_CYC       = DEF_DRAIN_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_en,
    input  logic [2:0] fn_sel,
    output logic       busy,
    output logic [3:0] cnt_cycle,
    output logic [2:0] cnt_data,
    output logic [3:0] grp_idx,
    output logic       word_valid,
    output logic       valid,
    output logic [6:0] f_en,
    output logic [6:0] clk_en,
    output logic       done
);

    localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

    generate
        if (WORDS_PER_GROUP > 8 || BYTES_PER_WORD > 16 || NUM_GROUPS > 16 || DRAIN_CYC < 1) begin : g_geom_err
            $error("iotdf_ctrl: geometry does not fit the fixed counter ports");
        end
    endgenerate

    state_t             state, state_nxt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [6:0]         gate_en;
    logic [6:0]         dec_f_en;
    logic [6:0]         dec_gate_en;
    logic               start, accept, last_byte, last_word, last_grp, drain_end;

    iotdf_fn_dec u_fn_dec (
        .fn_sel  (fn_sel),
        .f_en    (dec_f_en),
        .gate_en (dec_gate_en)
    );

    assign start      = (state == ST_IDLE) && (fn_sel != 3'd0);
    assign busy       = (state != ST_RUN);
    assign accept     = in_en && !busy;
    assign last_byte  = (cnt_cycle == 4'(BYTES_PER_WORD - 1));
    assign last_word  = (cnt_data == 3'(WORDS_PER_GROUP - 1));
    assign last_grp   = (grp_idx == 4'(NUM_GROUPS - 1));
    assign drain_end  = (state == ST_DRAIN) && (drain_cnt == DRAIN_W'(DRAIN_CYC - 1));
    // Strobes are decoded on the accepting cycle so the buffer loads the word in step.
    assign word_valid = accept && last_byte;
    assign valid      = word_valid && last_word;
    assign clk_en     = gate_en & {7{(state == ST_RUN) || (state == ST_DRAIN)}};

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (valid) state_nxt = last_grp ? ST_DRAIN : ST_STALL;
            ST_STALL: state_nxt = ST_RUN;
            ST_DRAIN: if (drain_end) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_cycle <= 4'd0;
            cnt_data  <= 3'd0;
            grp_idx   <= 4'd0;
        end else if (start) begin
            cnt_cycle <= 4'd0;
            cnt_data  <= 3'd0;
            grp_idx   <= 4'd0;
        end else if (accept) begin
            cnt_cycle <= last_byte ? 4'd0 : cnt_cycle + 4'd1;
            if (last_byte) begin
                cnt_data <= last_word ? 3'd0 : cnt_data + 3'd1;
            end
            if (valid) begin
                grp_idx <= grp_idx + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if (state != ST_DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_en    <= 7'd0;
            gate_en <= 7'd0;
            done    <= 1'b0;
        end else if (start) begin
            f_en    <= dec_f_en;
            gate_en <= dec_gate_en;
            done    <= 1'b0;
        end else if (drain_end) begin
            f_en    <= 7'd0;
            gate_en <= 7'd0;
            done    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_iotdf_ctrl.sv
// Directed bench for iotdf_ctrl: a byte-count based model is checked every cycle,
// with literal expectations pinning the model at key points of each scenario.
module tb_iotdf_ctrl;

    localparam int BPW = 16;
    localparam int BPG = 128;
    localparam int RUN_BYTES = 1536;

    logic       clk;
    logic       rst;
    logic       in_en;
    logic [2:0] fn_sel;
    logic       busy;
    logic [3:0] cnt_cycle;
    logic [2:0] cnt_data;
    logic [3:0] grp_idx;
    logic       word_valid;
    logic       valid;
    logic [6:0] f_en;
    logic [6:0] clk_en;
    logic       done;

    iotdf_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_en      (in_en),
        .fn_sel     (fn_sel),
        .busy       (busy),
        .cnt_cycle  (cnt_cycle),
        .cnt_data   (cnt_data),
        .grp_idx    (grp_idx),
        .word_valid (word_valid),
        .valid      (valid),
        .f_en       (f_en),
        .clk_en     (clk_en),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 run, 2 stall, 3 drain; position derived from bytes accepted.
    int         m_ph = 0;
    int         m_bytes = 0;
    int         m_drain = 0;
    logic [6:0] m_fen = 7'd0;
    logic       m_done = 1'b0;

    logic       s_busy, s_wv, s_v, s_done;
    logic [3:0] s_cc, s_gi;
    logic [2:0] s_cd;
    logic [6:0] s_fen, s_cen;
    int wv_seen = 0, v_seen = 0, acc_seen = 0, cen_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_bytes = 0; m_drain = 0; m_fen = 7'd0; m_done = 1'b0;
    endtask

    task automatic compare_cycle();
        logic        acc;
        logic [28:0] exp_v, act_v;
        logic [6:0]  exp_cen;
        if (rst) model_reset();
        acc     = (m_ph == 1) && in_en;
        exp_cen = (m_ph == 1 || m_ph == 3) ? (m_fen & 7'b1100111) : 7'd0;
        exp_v = {m_ph != 1, 4'(m_bytes % BPW), 3'((m_bytes / BPW) % 8), 4'(m_bytes / BPG),
                 acc && (m_bytes % BPW == BPW - 1), acc && (m_bytes % BPG == BPG - 1),
                 m_fen, exp_cen, m_done};
        act_v = {busy, cnt_cycle, cnt_data, grp_idx, word_valid, valid, f_en, clk_en, done};
        chk("cycle_outputs", 32'(act_v), 32'(exp_v));
        s_busy = busy; s_cc = cnt_cycle; s_cd = cnt_data; s_gi = grp_idx;
        s_wv = word_valid; s_v = valid; s_fen = f_en; s_cen = clk_en; s_done = done;
        wv_seen  += int'(word_valid);
        v_seen   += int'(valid);
        acc_seen += int'(in_en && !busy);
        cen_seen += int'(clk_en != 7'd0);
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            case (m_ph)
                0: if (fn_sel != 3'd0) begin
                       m_ph = 1; m_bytes = 0; m_done = 1'b0;
                       m_fen = 7'd1 << (fn_sel - 3'd1);
                   end
                1: if (in_en) begin
                       m_bytes++;
                       if (m_bytes % BPG == 0) begin
                           if (m_bytes == RUN_BYTES) begin m_ph = 3; m_drain = 2; end
                           else m_ph = 2;
                       end
                   end
                2: m_ph = 1;
                default: begin
                    m_drain--;
                    if (m_drain == 0) begin m_ph = 0; m_done = 1'b1; m_fen = 7'd0; end
                end
            endcase
        end
    endtask

    // One clock: check this cycle's outputs, then advance the model at the edge.
    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic feed(input int target, input int gap_mod);
        int cyc = 0;
        while (m_bytes < target && cyc < 4000) begin
            in_en = (gap_mod == 0) || (cyc % gap_mod != 0);
            tick();
            cyc++;
        end
        if (m_bytes < target) begin
            checks++; errors++;
            $display("FAIL feed_timeout: reached %0d bytes, needed %0d", m_bytes, target);
        end
    endtask

    task automatic wait_done(output int drain_cycles);
        drain_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_done) break;
            drain_cycles++;
        end
    endtask

    initial begin
        int drain, wv0, v0, acc0, cen0;
        logic [6:0] exp_fen;
        rst = 1'b1; in_en = 1'b0; fn_sel = 3'd0;
        tick(); tick();
        chk("reset_busy", 32'(s_busy), 32'd1);
        chk("reset_f_en", 32'(s_fen), 32'd0);
        rst = 1'b0;

        // fn_sel==0 keeps the sequencer idle even with bytes offered.
        in_en = 1'b1;
        tick(); tick(); tick();
        chk("idle_busy", 32'(s_busy), 32'd1);
        chk("idle_f_en", 32'(s_fen), 32'd0);
        fn_sel = 3'd6; tick();
        fn_sel = 3'd0; tick();
        chk("fn6_f_en", 32'(s_fen), 32'h20);

        // Abort at group 5, word 3, byte 9.
        feed(5 * BPG + 3 * BPW + 9, 0);
        in_en = 1'b0; tick();
        chk("pre_abort_pos", {20'd0, s_gi, 1'b0, s_cd, s_cc}, {20'd0, 4'd5, 1'b0, 3'd3, 4'd9});
        rst = 1'b1; in_en = 1'b1; tick();
        chk("abort_state", {22'd0, s_busy, s_cc, s_cd, s_gi, s_wv, s_v, s_done},
                           {22'd0, 1'b1, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b0});
        chk("abort_f_en", {18'd0, s_fen, s_cen}, 32'd0);
        tick();
        rst = 1'b0;

        // fn_sel=1: busy drops on the second cycle, one stall after the first group.
        fn_sel = 3'd1; in_en = 1'b1; tick();
        chk("fn1_cycle1_busy", 32'(s_busy), 32'd1);
        fn_sel = 3'd0; tick();
        chk("fn1_cycle2_busy", 32'(s_busy), 32'd0);
        feed(BPG, 0);
        chk("fn1_group_strobes", {30'd0, s_wv, s_v}, 32'd3);
        tick();
        chk("fn1_stall_busy", 32'(s_busy), 32'd1);
        chk("fn1_f_en", 32'(s_fen), 32'd1);
        tick();
        chk("fn1_resume_busy", 32'(s_busy), 32'd0);
        chk("fn1_clk_en", 32'(s_cen), 32'd1);
        chk("fn1_grp_idx", 32'(s_gi), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;

        // fn_sel=3 full run with input gaps; bytes offered through stall and drain.
        wv0 = wv_seen; v0 = v_seen; acc0 = acc_seen;
        in_en = 1'b0; fn_sel = 3'd3; tick();
        fn_sel = 3'd0;
        feed(RUN_BYTES, 5);
        in_en = 1'b1;
        wait_done(drain);
        chk("fn3_drain_cycles", 32'(drain), 32'd2);
        chk("fn3_done", 32'(s_done), 32'd1);
        chk("fn3_done_busy", 32'(s_busy), 32'd1);
        chk("fn3_done_f_en", 32'(s_fen), 32'd0);
        tick(); tick();
        chk("fn3_word_valid_count", 32'(wv_seen - wv0), 32'd96);
        chk("fn3_valid_count", 32'(v_seen - v0), 32'd12);
        chk("fn3_byte_count", 32'(acc_seen - acc0), 32'd1536);

        // f4/f5 never open a clock gate.
        for (int k = 4; k <= 5; k++) begin
            cen0 = cen_seen;
            exp_fen = (k == 4) ? 7'b0001000 : 7'b0010000;
            in_en = 1'b1; fn_sel = 3'(k); tick();
            fn_sel = 3'd0; tick();
            chk("fn45_f_en", 32'(s_fen), 32'(exp_fen));
            feed(RUN_BYTES, 0);
            wait_done(drain);
            chk("fn45_done", 32'(s_done), 32'd1);
            chk("fn45_clk_en_cycles", 32'(cen_seen - cen0), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
